mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, word-address width of the shared memory.
REQ-002 SHALL have parameter DW, default 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, number of consecutive denied cycles after which fetch is promoted.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ld_req, ld_we  input  1 each  loader request and write-enable.
REQ-007 ld_addr  input  AW  loader address.
REQ-008 ld_wdata  input  DW  loader write data.
REQ-009 ld_gnt  output  1  loader granted this cycle.
REQ-010 d_req, d_we  input  1 each  MEM-stage request and write-enable.
REQ-011 d_addr  input  AW  MEM-stage address.
REQ-012 d_wdata  input  DW  MEM-stage write data.
REQ-013 d_gnt, d_rvalid  output  1 each  MEM-stage grant and read-data valid.
REQ-014 d_rdata  output  DW  MEM-stage read data.
REQ-015 i_req  input  1  IF-stage fetch request (read only).
REQ-016 i_addr  input  AW  fetch address.
REQ-017 i_gnt, i_rvalid  output  1 each  fetch grant and instruction valid.
REQ-018 i_rdata  output  DW  fetched instruction.
REQ-019 mem_en, mem_we  output  1 each  memory strobe and write-enable.
REQ-020 mem_addr  output  AW  memory address.
REQ-021 mem_wdata  output  DW  memory write data.
REQ-022 mem_rdata  input  DW  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-023 fetch_stall  output  1  high when i_req=1 and i_gnt=0.

Function
REQ-024 Grant SHALL be combinational from current requests and registered state; at most one of ld_gnt, d_gnt, i_gnt high per cycle.
REQ-025 Base priority SHALL be loader > data > fetch.
REQ-026 Starvation counter (width clog2(STARVE_MAX+1)) SHALL increment each cycle i_req=1 and i_gnt=0, clear on i_gnt=1 or i_req=0, saturate at STARVE_MAX.
REQ-027 When counter equals STARVE_MAX, priority SHALL become fetch > loader > data for that cycle.
REQ-028 Winner's addr/we/wdata SHALL drive mem_addr/mem_we/mem_wdata with mem_en=1 in the grant cycle; with no request mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-029 A requester SHALL hold req and payload stable until its gnt; a granted request completes in that cycle, so back-to-back grants each cycle are allowed.
REQ-030 A registered owner tag (NONE/LD/D/I) and read flag SHALL record each read grant; in the next cycle d_rvalid or i_rvalid SHALL pulse one cycle for the recorded owner with mem_rdata routed to d_rdata or i_rdata.
REQ-031 Write grants SHALL produce no rvalid; loader reads produce no rvalid (loader is write-only in use).
REQ-032 d_rdata and i_rdata SHALL be registered copies of the last data delivered and hold value between rvalid pulses.
REQ-033 Same-cycle read response and new grant SHALL both proceed (read latency pipelined, throughput one access per cycle).
REQ-034 fetch_stall SHALL be combinational: i_req & ~i_gnt.

Reset
REQ-035 rst_n=0 SHALL asynchronously clear owner tag to NONE, starvation counter to 0, d_rvalid, i_rvalid to 0, d_rdata, i_rdata to 0.
REQ-036 Grants and mem_en SHALL be 0 while rst_n=0; a read issued the cycle before reset assertion SHALL produce no rvalid after release.
REQ-037 First grant after rst_n rises SHALL follow base priority with counter 0.

Verification
REQ-038 Only i_req=1, i_addr=5, mem holds 0x28020014 at 5 -> i_gnt same cycle, i_rvalid=1, i_rdata=0x28020014 next cycle.
REQ-039 d_req (read, addr 3) and i_req same cycle -> d_gnt first, i_gnt next cycle, fetch_stall=1 for exactly one cycle, rvalids in consecutive cycles to correct owners.
REQ-040 d_req held continuously with i_req, STARVE_MAX=4 -> i_gnt on 5th cycle, counter clears, d_gnt resumes following cycle.
REQ-041 Loader writes 0xfc000000 to addr 8 while i_req pending -> ld_gnt, mem_we=1, mem_wdata=0xfc000000, no rvalid; fetch later reads 0xfc000000 from 8.
REQ-042 Assert rst_n=0 mid-cycle after a data read grant -> d_rvalid stays 0, counter and owner cleared immediately.
REQ-043 No requests for 10 cycles -> mem_en=0, all gnt and rvalid 0, rdata outputs hold previous values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the loader, MEM-stage data port and IF-stage fetch.
// Grants are combinational; read data comes back one cycle later to whichever port owned the read.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ld_req,
    input  logic                              ld_we,
    input  logic [AW-1:0]                     ld_addr,
    input  logic [DW-1:0]                     ld_wdata,
    output logic                              ld_gnt,
    input  logic                              d_req,
    input  logic                              d_we,
    input  logic [AW-1:0]                     d_addr,
    input  logic [DW-1:0]                     d_wdata,
    output logic                              d_gnt,
    output logic                              d_rvalid,
    output logic [DW-1:0]                     d_rdata,
    input  logic                              i_req,
    input  logic [AW-1:0]                     i_addr,
    output logic                              i_gnt,
    output logic                              i_rvalid,
    output logic [DW-1:0]                     i_rdata,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [AW-1:0]                     mem_addr,
    output logic [DW-1:0]                     mem_wdata,
    input  logic [DW-1:0]                     mem_rdata,
    output logic                              fetch_stall,
    output logic [1:0]                        owner_state,
    output logic [$clog2(STARVE_MAX+1)-1:0]   starve_count
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_D    = 2'd2,
        OWN_I    = 2'd3
    } owner_t;

    owner_t        owner_q, owner_d;
    logic          rd_q, rd_d;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] d_hold_q, i_hold_q;
    logic          promote;

    assign promote = (cnt_q == CW'(STARVE_MAX));

    // Grants are gated by rst_n so nothing is issued while reset is held.
    always_comb begin
        ld_gnt    = 1'b0;
        d_gnt     = 1'b0;
        i_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (rst_n) begin
            if (promote && i_req)  i_gnt  = 1'b1;
            else if (ld_req)       ld_gnt = 1'b1;
            else if (d_req)        d_gnt  = 1'b1;
            else if (i_req)        i_gnt  = 1'b1;
        end
        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            owner_d   = OWN_LD;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            owner_d   = OWN_D;
        end else if (i_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr;
            owner_d   = OWN_I;
        end
        rd_d = mem_en & ~mem_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            rd_q     <= 1'b0;
            cnt_q    <= '0;
            d_hold_q <= '0;
            i_hold_q <= '0;
        end else begin
            owner_q <= owner_d;
            rd_q    <= rd_d;
            if (i_req && !i_gnt) begin
                if (!promote) cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
            if (d_rvalid) d_hold_q <= mem_rdata;
            if (i_rvalid) i_hold_q <= mem_rdata;
        end
    end

    assign d_rvalid = rd_q && (owner_q == OWN_D);
    assign i_rvalid = rd_q && (owner_q == OWN_I);

    // The memory output is only valid in the response cycle, so it is passed straight
    // through then and the captured copy is shown between responses.
    assign d_rdata = d_rvalid ? mem_rdata : d_hold_q;
    assign i_rdata = i_rvalid ? mem_rdata : i_hold_q;

    assign fetch_stall  = i_req & ~i_gnt;
    assign owner_state  = owner_q;
    assign starve_count = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter with a synchronous memory model and a read-response scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 4;
    localparam int CW = $clog2(SM + 1);
    localparam logic [1:0] G_NONE = 2'd0, G_LD = 2'd1, G_D = 2'd2, G_I = 2'd3;

    logic          clk, rst_n;
    logic          ld_req, ld_we, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          fetch_stall;
    logic [1:0]    owner_state;
    logic [CW-1:0] starve_count;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] last_d, last_i;
    int            checks = 0;
    int            errors = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fetch_stall(fetch_stall),
        .owner_state(owner_state), .starve_count(starve_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // synchronous memory model: read data valid the cycle after a read strobe
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        for (int k = 0; k < (1 << AW); k++) begin
            mem[k]     = DW'(k) * 32'h01010101 + 32'h11;
            ref_mem[k] = DW'(k) * 32'h01010101 + 32'h11;
        end
        mem[5]     = 32'h28020014;
        ref_mem[5] = 32'h28020014;
        mem_rdata  = '0;
    end

    task automatic clear_inputs();
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        i_req = 0; i_addr = '0;
    endtask

    // One cycle: called at a negedge with inputs applied; checks grants, memory strobe,
    // stall and read responses, then advances to the next negedge.
    task automatic run_cycle(input logic [1:0] eg);
        logic [2:0]          exp_gnt;
        logic [AW+DW+1:0]    exp_mem;
        logic [DW:0]         e;
        #1;
        exp_gnt = {eg == G_LD, eg == G_D, eg == G_I};
        checks++;
        if ({ld_gnt, d_gnt, i_gnt} !== exp_gnt) begin
            errors++;
            $display("FAIL gnt: got %b expected %b at %0t", {ld_gnt, d_gnt, i_gnt}, exp_gnt, $time);
        end
        case (eg)
            G_LD:    exp_mem = {1'b1, ld_we, ld_addr, ld_wdata};
            G_D:     exp_mem = {1'b1, d_we, d_addr, d_wdata};
            G_I:     exp_mem = {1'b1, 1'b0, i_addr, {DW{1'b0}}};
            default: exp_mem = '0;
        endcase
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== exp_mem) begin
            errors++;
            $display("FAIL mem_bus: got %h expected %h at %0t",
                     {mem_en, mem_we, mem_addr, mem_wdata}, exp_mem, $time);
        end
        checks++;
        if (fetch_stall !== (i_req && eg != G_I)) begin
            errors++;
            $display("FAIL fetch_stall: got %b expected %b at %0t", fetch_stall, (i_req && eg != G_I), $time);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[DW]) last_i = e[DW-1:0];
            else       last_d = e[DW-1:0];
            checks++;
            if ({i_rvalid, d_rvalid} !== (e[DW] ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rvalid: got %b expected %b at %0t", {i_rvalid, d_rvalid},
                         (e[DW] ? 2'b10 : 2'b01), $time);
            end
        end else begin
            checks++;
            if ({i_rvalid, d_rvalid} !== 2'b00) begin
                errors++;
                $display("FAIL rvalid_idle: got %b expected 00 at %0t", {i_rvalid, d_rvalid}, $time);
            end
        end
        checks++;
        if (d_rdata !== last_d || i_rdata !== last_i) begin
            errors++;
            $display("FAIL rdata: got d=%h i=%h expected d=%h i=%h at %0t",
                     d_rdata, i_rdata, last_d, last_i, $time);
        end
        if (eg == G_D && !d_we) exp_q.push_back({1'b0, ref_mem[d_addr]});
        if (eg == G_I)          exp_q.push_back({1'b1, ref_mem[i_addr]});
        if (eg == G_LD && ld_we) ref_mem[ld_addr] = ld_wdata;
        if (eg == G_D && d_we)   ref_mem[d_addr]  = d_wdata;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0; d_req = 1; i_req = 1; i_addr = 10'd5; ld_req = 1; ld_we = 1;
        last_d = '0; last_i = '0;
        @(negedge clk); #1;
        checks++;
        if ({ld_gnt, d_gnt, i_gnt, mem_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt: got %b expected 0000", {ld_gnt, d_gnt, i_gnt, mem_en});
        end
        checks++;
        if ({d_rvalid, i_rvalid, owner_state, starve_count} !== '0 || d_rdata !== '0 || i_rdata !== '0) begin
            errors++;
            $display("FAIL reset_state: got rv=%b own=%0d cnt=%0d d=%h i=%h expected all 0",
                     {d_rvalid, i_rvalid}, owner_state, starve_count, d_rdata, i_rdata);
        end
        @(negedge clk);
        rst_n = 1;
        // first grant after reset follows base priority
        ld_addr = 10'd20; ld_wdata = 32'h0badf00d;
        d_addr = 10'd3;
        run_cycle(G_LD);
        ld_req = 0; ld_we = 0;
        run_cycle(G_D);
        d_req = 0;
        run_cycle(G_I);
        i_req = 0;
        run_cycle(G_NONE);
    endtask

    task automatic test_single_fetch();
        clear_inputs();
        i_req = 1; i_addr = 10'd5;
        run_cycle(G_I);
        i_req = 0;
        run_cycle(G_NONE);
        checks++;
        if (i_rdata !== 32'h28020014) begin
            errors++;
            $display("FAIL fetch_addr5: got %h expected 28020014", i_rdata);
        end
    endtask

    task automatic test_contention();
        clear_inputs();
        d_req = 1; d_addr = 10'd3; i_req = 1; i_addr = 10'd5;
        run_cycle(G_D);
        d_req = 0;
        run_cycle(G_I);
        i_req = 0;
        run_cycle(G_NONE);
        run_cycle(G_NONE);
    endtask

    task automatic test_starvation();
        clear_inputs();
        d_req = 1; d_addr = 10'd3; i_req = 1; i_addr = 10'd7;
        for (int c = 0; c < SM; c++) run_cycle(G_D);
        checks++;
        if (starve_count !== CW'(SM)) begin
            errors++;
            $display("FAIL starve_sat: got %0d expected %0d", starve_count, SM);
        end
        run_cycle(G_I);
        checks++;
        if (starve_count !== '0) begin
            errors++;
            $display("FAIL starve_clear: got %0d expected 0", starve_count);
        end
        i_req = 0;
        run_cycle(G_D);
        d_req = 0;
        run_cycle(G_NONE);
    endtask

    task automatic test_loader_write();
        clear_inputs();
        ld_req = 1; ld_we = 1; ld_addr = 10'd8; ld_wdata = 32'hfc000000;
        i_req = 1; i_addr = 10'd8;
        run_cycle(G_LD);
        ld_req = 0; ld_we = 0;
        run_cycle(G_I);
        i_req = 0;
        run_cycle(G_NONE);
        checks++;
        if (i_rdata !== 32'hfc000000) begin
            errors++;
            $display("FAIL loader_readback: got %h expected fc000000", i_rdata);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        for (int k = 0; k < 6; k++) begin
            ld_req = 1; ld_we = 1; ld_addr = AW'(32 + k); ld_wdata = $urandom;
            run_cycle(G_LD);
        end
        clear_inputs();
        for (int k = 0; k < 8; k++) begin
            i_req = 1; i_addr = AW'($urandom_range(30, 40));
            run_cycle(G_I);
        end
        i_req = 0;
        for (int k = 0; k < 6; k++) begin
            d_req = 1; d_we = ($urandom_range(0, 1) == 1);
            d_addr = AW'($urandom_range(30, 40)); d_wdata = $urandom;
            run_cycle(G_D);
        end
        clear_inputs();
        run_cycle(G_NONE);
    endtask

    task automatic test_idle();
        clear_inputs();
        for (int k = 0; k < 10; k++) run_cycle(G_NONE);
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        d_req = 1; d_addr = 10'd3; i_req = 1; i_addr = 10'd5;
        run_cycle(G_D);
        #1;
        checks++;
        if (d_gnt !== 1'b1 || starve_count !== CW'(1)) begin
            errors++;
            $display("FAIL mid_pre: got gnt=%b cnt=%0d expected gnt=1 cnt=1", d_gnt, starve_count);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({d_gnt, mem_en, d_rvalid, owner_state, starve_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got gnt=%b en=%b rv=%b own=%0d cnt=%0d expected all 0",
                     d_gnt, mem_en, d_rvalid, owner_state, starve_count);
        end
        exp_q.delete();
        last_d = '0; last_i = '0;
        clear_inputs();
        @(posedge clk); #1;
        checks++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_hold: got rv=%b expected 00", {i_rvalid, d_rvalid});
        end
        @(negedge clk);
        rst_n = 1;
        run_cycle(G_NONE);
        run_cycle(G_NONE);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_loader_write();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending responses expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
